// File: rtl/tile_exerciser.sv
// rtl/tile_exerciser.sv - LFSR stimulus generator with MISR response compaction for tile test
//
// Purpose: drives N_VECTORS pseudo-random 8-bit vectors into a tile, holds each for
// SETTLE cycles, captures the tile response into a 16-bit MISR and reports the
// resulting signature.
//
// Optional feature: define TILE_EXERCISER_COMPARE_EN to add a registered
// signature comparison (expected / pass ports).
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   start      in   1  run request, honoured in IDLE or DONE only
//   stim_out   out  8  registered stimulus (LFSR value while busy, else 0)
//   resp_in    in   8  tile response, folded into the MISR on each capture
//   busy       out  1  run in progress
//   done       out  1  run complete, held until the next accepted start
//   signature  out 16  MISR state
//   expected   in  16  reference signature (TILE_EXERCISER_COMPARE_EN only)
//   pass       out  1  done && signature == expected, registered (TILE_EXERCISER_COMPARE_EN only)
module tile_exerciser #(
    parameter int         N_VECTORS = 256,
    parameter int         SETTLE    = 2,
    parameter logic [7:0] SEED      = 8'h01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  stim_out,
    input  logic [7:0]  resp_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature
`ifdef TILE_EXERCISER_COMPARE_EN
    ,
    input  logic [15:0] expected,
    output logic        pass
`endif
);

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [7:0]  SEED_EFF    = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [15:0] N_LIMIT     = 16'(N_VECTORS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  lfsr;
    logic [15:0] misr;
    logic [15:0] vec_cnt;
    logic [3:0]  set_cnt;

    logic        accept;
    logic        last_vec;
    logic        settle_end;
    logic [7:0]  lfsr_next;
    logic [15:0] misr_next;
    logic [15:0] vec_inc;

    assign lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign misr_next  = {misr[14:0], misr[15] ^ misr[14] ^ misr[12] ^ misr[3]}
                        ^ {8'h00, resp_in};
    assign vec_inc    = vec_cnt + 16'd1;
    // vec_inc is the count after the capture in progress; it cannot wrap
    // because N_VECTORS never exceeds 65535.
    assign last_vec   = (vec_inc >= N_LIMIT);
    assign settle_end = (set_cnt == SETTLE_LAST);
    assign signature  = misr;

    always_comb begin
        accept     = 1'b0;
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_end) begin
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_next = last_vec ? S_DONE : S_SETTLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            lfsr     <= SEED_EFF;
            misr     <= 16'h0000;
            vec_cnt  <= 16'h0000;
            set_cnt  <= 4'h0;
            busy     <= 1'b0;
            done     <= 1'b0;
            stim_out <= 8'h00;
        end else begin
            state <= state_next;
            if (accept) begin
                lfsr     <= SEED_EFF;
                misr     <= 16'h0000;
                vec_cnt  <= 16'h0000;
                set_cnt  <= 4'h0;
                busy     <= 1'b1;
                done     <= 1'b0;
                stim_out <= SEED_EFF;
            end else begin
                case (state)
                    S_SETTLE: begin
                        set_cnt <= settle_end ? 4'h0 : set_cnt + 4'h1;
                    end
                    S_CAPTURE: begin
                        misr    <= misr_next;
                        lfsr    <= lfsr_next;
                        vec_cnt <= vec_inc;
                        if (last_vec) begin
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            stim_out <= 8'h00;
                        end else begin
                            stim_out <= lfsr_next;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef TILE_EXERCISER_COMPARE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass <= 1'b0;
        end else begin
            pass <= done && (misr == expected);
        end
    end
`endif

endmodule

// File: doc/tile_exerciser.md
TILE_EXERCISER -- requirements
Module: tile_exerciser

Interface
REQ-001 SHALL have parameter N_VECTORS, default 256, meaning the number of stimulus vectors per run (legal range 1..65535).
REQ-002 SHALL have parameter SETTLE, default 2, meaning the number of cycles each vector is held before the response is captured (legal range 1..15).
REQ-003 SHALL have parameter SEED, default 8'h01, meaning the initial LFSR value; a value of 8'h00 SHALL be replaced by 8'h01.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit: run request, sampled on the rising edge.
REQ-007 SHALL have port stim_out, output, 8 bits: stimulus, wired to a tile's ui_in.
REQ-008 SHALL have port resp_in, input, 8 bits: response, wired from the tile's uo_out.
REQ-009 SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-010 SHALL have port done, output, 1 bit: high once a run completes, held until the next accepted start.
REQ-011 SHALL have port signature, output, 16 bits: MISR state.

Function
REQ-012 SHALL implement the FSM states IDLE, SETTLE, CAPTURE and DONE.
REQ-013 SHALL accept start only in IDLE or DONE; start in SETTLE or CAPTURE SHALL be ignored.
REQ-014 On accepting start, on that same edge the block SHALL: load LFSR=SEED, clear MISR to 16'h0000, clear the vector and settle counters, set busy=1, set done=0, and enter SETTLE.
REQ-015 SETTLE SHALL last exactly SETTLE cycles, with stim_out stable and equal to the LFSR value, then go to CAPTURE.
REQ-016 CAPTURE SHALL last one cycle and SHALL do the following on its closing edge: MISR <= {MISR[14:0], fb} ^ {8'h00, resp_in}, with fb = MISR[15]^MISR[14]^MISR[12]^MISR[3]; LFSR advances; vector count increments.
REQ-017 The LFSR next-state SHALL be {L[6:0], L[7]^L[5]^L[4]^L[3]} (period 255; from 8'h01 the sequence is 01,02,04,08,11,23).
REQ-018 After CAPTURE the FSM SHALL return to SETTLE if the vector count is below N_VECTORS, and otherwise go to DONE.
REQ-019 On entering DONE, busy SHALL drop and done SHALL rise on the same edge; busy SHALL have been high for exactly N_VECTORS*(SETTLE+1) cycles.
REQ-020 stim_out SHALL be registered and SHALL equal the LFSR value while busy=1, and 8'h00 otherwise.
REQ-021 signature SHALL be held stable in DONE and IDLE until the next accepted start.
REQ-022 A start asserted in DONE SHALL restart the run with no intervening IDLE cycle.
REQ-023 Vector count wrap SHALL NOT occur: the counter is 16 bits and N_VECTORS is at most 65535.

Reset
REQ-024 While rst_n=0, asynchronously: state=IDLE, busy=0, done=0, stim_out=8'h00, signature=16'h0000, LFSR=SEED (or 8'h01 if SEED is zero), counters=0.
REQ-025 Reset during a run SHALL abort it immediately; after reset release no run SHALL begin without a new start.

Configuration
REQ-026 With macro TILE_EXERCISER_COMPARE_EN defined, the block SHALL add input expected (16 bits) and output pass (1 bit), with pass = done && (signature == expected), registered, and reset to 0.
REQ-027 Without TILE_EXERCISER_COMPARE_EN, neither port SHALL exist and no compare logic SHALL be present.

Verification
REQ-028 Reset then release, SEED=01, N_VECTORS=6, SETTLE=1, start pulse -> stim_out is 01,02,04,08,11,23, each held 2 cycles; busy high for 12 cycles; done rises as busy falls.
REQ-029 Hold resp_in=8'h00 throughout a run -> signature=16'h0000 at done.
REQ-030 N_VECTORS=2, resp_in held at 8'hA5 -> signature 16'h00A5 after the first CAPTURE and 16'h01EF at done.
REQ-031 Pulse start mid-run, then rst_n low for 1 cycle mid-run -> the start is ignored; reset returns all outputs to reset values and the block stays in IDLE.
REQ-032 Start asserted in DONE -> done drops and busy rises on the same edge; the second run with identical resp_in yields an identical signature.
REQ-033 With TILE_EXERCISER_COMPARE_EN, expected=16'h01EF under the REQ-030 stimulus -> pass=1; with expected=16'h01EE -> pass=0.
